// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction fetch queue between fetch and decode.
// Captures {PC, instruction} pairs from fetch and presents them to decode
// through a valid/ready handshake. It stalls fetch when full and discards
// every buffered entry on a taken branch or jump from execute.
//
// Ports:
//   Clk, Reset          clock; synchronous active-high reset
//   IF_valid            fetch presents IF_PC / IF_Instruction this cycle
//   IF_PC               PC of the fetched instruction
//   IF_Instruction      fetched instruction word
//   IF_stall            queue full; fetch must hold its PC
//   EX_PC_source_sel    taken branch/jump in execute; flush the queue
//   ID_ready            decode accepts the head entry this cycle
//   ID_valid            head entry is valid
//   ID_PC               head entry PC (0 when empty)
//   ID_Instruction      head entry instruction (NOP_INSTR when empty)
//   count               current occupancy, 0..DEPTH
module fetch_queue #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         IF_valid,
    input  logic [ADDR_WIDTH-1:0]        IF_PC,
    input  logic [DATA_WIDTH-1:0]        IF_Instruction,
    output logic                         IF_stall,
    input  logic                         EX_PC_source_sel,
    input  logic                         ID_ready,
    output logic                         ID_valid,
    output logic [ADDR_WIDTH-1:0]        ID_PC,
    output logic [DATA_WIDTH-1:0]        ID_Instruction,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;
    entry_t           head;

    // Status and head view come from registered state only.
    always_comb begin
        ID_valid = (cnt != '0);
        IF_stall = (cnt == CNT_W'(DEPTH));
        head     = mem[rd_ptr];
        if (ID_valid) begin
            ID_PC          = head.pc;
            ID_Instruction = head.instr;
        end else begin
            ID_PC          = '0;
            ID_Instruction = NOP_INSTR;
        end
        count = cnt;
    end

    // A flush cancels both sides of the handshake in the same cycle.
    always_comb begin
        push = IF_valid & ~IF_stall & ~EX_PC_source_sel;
        pop  = ID_valid & ID_ready  & ~EX_PC_source_sel;
    end

    // Pointers and occupancy; reset and flush both return to empty.
    always_ff @(posedge Clk) begin
        if (Reset || EX_PC_source_sel) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Storage is never reset; only the pointers qualify its contents.
    always_ff @(posedge Clk) begin
        if (push && !Reset) begin
            mem[wr_ptr] <= '{pc: IF_PC, instr: IF_Instruction};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4).
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        IF_valid;
    logic [31:0] IF_PC;
    logic [31:0] IF_Instruction;
    logic        IF_stall;
    logic        EX_PC_source_sel;
    logic        ID_ready;
    logic        ID_valid;
    logic [31:0] ID_PC;
    logic [31:0] ID_Instruction;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    fetch_queue #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH(4),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .IF_valid(IF_valid),
        .IF_PC(IF_PC),
        .IF_Instruction(IF_Instruction),
        .IF_stall(IF_stall),
        .EX_PC_source_sel(EX_PC_source_sel),
        .ID_ready(ID_ready),
        .ID_valid(ID_valid),
        .ID_PC(ID_PC),
        .ID_Instruction(ID_Instruction),
        .count(count)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, check invariants.
    task automatic tick();
        @(posedge Clk);
        #1;
        chk("count_le_depth", 32'(count <= 3'd4), 32'd1);
        chk("full_flags", 32'(!(count == 3'd4 && !ID_valid && !IF_stall)), 32'd1);
    endtask

    initial begin
        Reset            = 1'b1;
        IF_valid         = 1'b0;
        IF_PC            = '0;
        IF_Instruction   = '0;
        EX_PC_source_sel = 1'b0;
        ID_ready         = 1'b0;

        // Reset for two cycles
        tick();
        tick();
        Reset = 1'b0;
        chk("rst_valid", 32'(ID_valid), 32'd0);
        chk("rst_stall", 32'(IF_stall), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_instr", ID_Instruction, NOP);
        chk("rst_pc", ID_PC, 32'd0);

        // Single push, visible next cycle
        IF_valid       = 1'b1;
        IF_PC          = 32'h0;
        IF_Instruction = 32'h0050_0093;
        tick();
        IF_valid = 1'b0;
        chk("one_valid", 32'(ID_valid), 32'd1);
        chk("one_pc", ID_PC, 32'h0);
        chk("one_instr", ID_Instruction, 32'h0050_0093);
        chk("one_count", 32'(count), 32'd1);
        ID_ready = 1'b1;
        tick();
        ID_ready = 1'b0;
        chk("one_drain", 32'(count), 32'd0);

        // Push five with decode stalled; fifth is refused
        for (int i = 0; i < 5; i++) begin
            IF_valid       = 1'b1;
            IF_PC          = 32'(4 * i);
            IF_Instruction = 32'h1000 + 32'(i);
            tick();
            if (i == 2) begin
                chk("fill3_stall", 32'(IF_stall), 32'd0);
                chk("fill3_count", 32'(count), 32'd3);
            end
            if (i >= 3) begin
                chk("full_stall", 32'(IF_stall), 32'd1);
                chk("full_count", 32'(count), 32'd4);
            end
        end
        IF_valid = 1'b0;
        chk("full_head", ID_PC, 32'h0);
        ID_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("drain_pc", ID_PC, 32'(4 * j));
            chk("drain_instr", ID_Instruction, 32'h1000 + 32'(j));
            tick();
        end
        ID_ready = 1'b0;
        chk("drain_valid", 32'(ID_valid), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_instr_nop", ID_Instruction, NOP);

        // Steady stream across three pointer wraps
        IF_valid       = 1'b1;
        ID_ready       = 1'b1;
        IF_PC          = 32'h100;
        IF_Instruction = 32'h2000;
        tick();
        for (int k = 1; k <= 12; k++) begin
            IF_PC          = 32'h100 + 32'(4 * k);
            IF_Instruction = 32'h2000 + 32'(k);
            chk("stream_pc", ID_PC, 32'h100 + 32'(4 * (k - 1)));
            chk("stream_instr", ID_Instruction, 32'h2000 + 32'(k - 1));
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_stall", 32'(IF_stall), 32'd0);
            tick();
        end
        IF_valid = 1'b0;
        chk("stream_last", ID_PC, 32'h130);
        tick();
        ID_ready = 1'b0;
        chk("stream_empty", 32'(count), 32'd0);

        // Fill three, then flush with a push and pop pending
        for (int i = 0; i < 3; i++) begin
            IF_valid       = 1'b1;
            IF_PC          = 32'h20 + 32'(4 * i);
            IF_Instruction = 32'h4000 + 32'(i);
            tick();
        end
        chk("pre_flush_count", 32'(count), 32'd3);
        EX_PC_source_sel = 1'b1;
        IF_PC            = 32'h40;
        IF_Instruction   = 32'h5555;
        ID_ready         = 1'b1;
        tick();
        EX_PC_source_sel = 1'b0;
        IF_valid         = 1'b0;
        ID_ready         = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(ID_valid), 32'd0);
        chk("flush_stall", 32'(IF_stall), 32'd0);
        chk("flush_pc", ID_PC, 32'd0);
        chk("flush_instr", ID_Instruction, NOP);
        IF_valid       = 1'b1;
        IF_PC          = 32'h80;
        IF_Instruction = 32'h3000;
        tick();
        IF_valid = 1'b0;
        chk("post_flush_pc", ID_PC, 32'h80);
        chk("post_flush_instr", ID_Instruction, 32'h3000);
        chk("post_flush_count", 32'(count), 32'd1);
        ID_ready = 1'b1;
        tick();
        ID_ready = 1'b0;
        chk("post_flush_empty", 32'(ID_valid), 32'd0);

        // Fill to full, then reset with handshakes active
        for (int i = 0; i < 4; i++) begin
            IF_valid       = 1'b1;
            IF_PC          = 32'h50 + 32'(4 * i);
            IF_Instruction = 32'h6000 + 32'(i);
            tick();
        end
        chk("pre_rst_stall", 32'(IF_stall), 32'd1);
        Reset    = 1'b1;
        ID_ready = 1'b1;
        tick();
        Reset    = 1'b0;
        IF_valid = 1'b0;
        ID_ready = 1'b0;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_stall", 32'(IF_stall), 32'd0);
        chk("mid_rst_valid", 32'(ID_valid), 32'd0);
        chk("mid_rst_instr", ID_Instruction, NOP);
        tick();
        chk("mid_rst_hold", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch queue between the fetch stage (PC + IMEM) and the decode stage.
- Consumer end of the fetch interface: captures each fetched {PC, instruction} pair and presents it to decode in order through a valid/ready handshake.
- Back-pressures fetch through the fetch-stage stall input.
- Discards all buffered entries on a taken branch or jump from execute.

Parameters:
ADDR_WIDTH, 32, width of PC and instruction address
DATA_WIDTH, 32, instruction width
DEPTH, 4, number of entries; power of two, >= 2
NOP_INSTR, 32'h00000013, value driven on ID_Instruction when the queue is empty (addi x0,x0,0)

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  synchronous, active-high reset
IF_valid  input  1  fetch stage presents a valid PC/instruction this cycle
IF_PC  input  ADDR_WIDTH  PC of the fetched instruction
IF_Instruction  input  DATA_WIDTH  fetched instruction word
IF_stall  output  1  queue full; fetch must hold its PC
EX_PC_source_sel  input  1  taken branch or jump in execute; flush the queue
ID_ready  input  1  decode accepts the head entry this cycle
ID_valid  output  1  head entry is valid
ID_PC  output  ADDR_WIDTH  PC of the head entry
ID_Instruction  output  DATA_WIDTH  instruction of the head entry
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset: wr_ptr = 0, rd_ptr = 0, count = 0.
  - Outputs after reset: ID_valid = 0, IF_stall = 0, ID_PC = 0, ID_Instruction = NOP_INSTR.
  - Reset takes priority over all other inputs.
  - Reset mid-operation discards all entries the next cycle.
- State: DEPTH-entry storage array; wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally; count is a separate register.
- Derived outputs (combinational from registered state only, no input-to-output paths):
  - ID_valid = (count != 0)
  - IF_stall = (count == DEPTH)
  - ID_PC / ID_Instruction = head entry when ID_valid, else 0 / NOP_INSTR
- push = IF_valid & ~IF_stall & ~EX_PC_source_sel; writes {IF_PC, IF_Instruction} at wr_ptr; wr_ptr += 1.
- pop = ID_valid & ID_ready & ~EX_PC_source_sel; rd_ptr += 1.
- count update: push only +1; pop only -1; push and pop together: unchanged.
- IF_valid while full: no write, no state change. Fetch holds its value because IF_stall = 1.
- Push and pop on a full queue cannot occur together: IF_stall already blocks the push. The freed slot is usable the next cycle.
- Latency: an entry pushed in cycle N is visible on ID_* in cycle N+1. There is no same-cycle bypass when empty.
- Ordering: strict FIFO.
- Flush (EX_PC_source_sel = 1): overrides push and pop.
  - Next cycle: wr_ptr = rd_ptr = 0, count = 0, ID_valid = 0, IF_stall = 0.
  - The IF_valid data presented in the flush cycle is dropped.
- ID_ready while empty: ignored.
- Storage contents are not reset; only pointers and count are.
- Assertions for the bench: count <= DEPTH; ID_valid and IF_stall never both 0 with count == DEPTH.

Test Plan:
- Reset for 2 cycles, then release → ID_valid = 0, IF_stall = 0, count = 0, ID_Instruction = 32'h00000013, ID_PC = 0.
- Push PC = 0x0, instr = 0x00500093 with ID_ready = 0 → next cycle ID_valid = 1, ID_PC = 0x0, ID_Instruction = 0x00500093, count = 1.
- Push 5 consecutive PCs 0x0..0x10 with ID_ready = 0, DEPTH = 4 → IF_stall = 1 after the 4th push, 5th not accepted, count = 4. Then pop 4 with ID_ready = 1 → PCs 0x0, 0x4, 0x8, 0xC in order.
- Steady stream with IF_valid = 1 and ID_ready = 1 for 12 cycles (pointer wrap ×3) → count stays at 1, each PC appears exactly once in order, no stalls.
- Fill to count = 3, then assert EX_PC_source_sel with IF_valid = 1 (PC 0x40) and ID_ready = 1 → next cycle count = 0, ID_valid = 0. PC 0x40 is not later seen. A push of PC 0x80 the cycle after appears at the head.
- Fill to 4 (IF_stall = 1), assert Reset for 1 cycle alongside IF_valid and ID_ready → next cycle count = 0, IF_stall = 0, ID_valid = 0, ID_Instruction = NOP_INSTR.
